// File: rtl/grf_wb_pkg.sv
// Shared MIPS pipeline macros and register-file types.
// Later files in the compilation unit rely on these macros, so this file is compiled first.
`ifndef GRF_WB_COMMON_DEFINES
`define GRF_WB_COMMON_DEFINES
`define PC_Reset 32'h0000_3000
`define REG_ZERO 5'd0
`endif

package grf_wb_pkg;
    localparam int unsigned PC_W = 32;

    typedef logic [PC_W-1:0] pc_t;
endpackage

// File: rtl/grf_read_port.sv
// One register-file read port: returns zero for $0 and in reset, then the WB bypass, then storage.
module grf_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              commit,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] data
);
    // NOTE: the output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        data = '0;
        if (!clear && addr != `REG_ZERO) begin
            if (commit && w_addr == addr) data = w_data;
            else                          data = stored;
        end
    end
endmodule

// File: rtl/grf_wb.sv
// Writeback register file: 32x32 storage, two bypassed read ports, a registered commit trace
// and a commit counter.
module grf_wb
    import grf_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_en,
    input  pc_t               w_pc,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [ADDR_W-1:0] r2_addr,
    output logic [DATA_W-1:0] r1_data,
    output logic [DATA_W-1:0] r2_data,
    output logic              trc_valid,
    output pc_t               trc_pc,
    output logic [ADDR_W-1:0] trc_addr,
    output logic [DATA_W-1:0] trc_data,
    output logic [CNT_W-1:0]  commit_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              commit;

    // A write presented during reset is discarded, and writes to $0 never count.
    assign commit = w_en && (w_addr != `REG_ZERO) && !reset;

    // NOTE: the storage array is reset explicitly because software may read any register
    // before writing it; entry 0 is cleared here and never written afterwards.
    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trc_valid  <= 1'b0;
            trc_pc     <= `PC_Reset;
            trc_addr   <= `REG_ZERO;
            trc_data   <= '0;
            commit_cnt <= '0;
        end else begin
            trc_valid <= commit;
            if (commit) begin
                trc_pc     <= w_pc;
                trc_addr   <= w_addr;
                trc_data   <= w_data;
                commit_cnt <= commit_cnt + CNT_W'(1);
            end
        end
    end

    grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
        .clear  (reset),
        .addr   (r1_addr),
        .stored (regs[r1_addr]),
        .commit (commit),
        .w_addr (w_addr),
        .w_data (w_data),
        .data   (r1_data)
    );

    grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
        .clear  (reset),
        .addr   (r2_addr),
        .stored (regs[r2_addr]),
        .commit (commit),
        .w_addr (w_addr),
        .w_data (w_data),
        .data   (r2_data)
    );
endmodule

// File: tb/tb_grf_wb.sv
// Directed testbench for grf_wb; a second instance with a 4-bit counter shares all inputs.
module tb_grf_wb;
    logic        clk = 1'b0;
    logic        reset;
    logic        w_en;
    logic [31:0] w_pc;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  r1_addr;
    logic [4:0]  r2_addr;

    logic [31:0] r1_data, r2_data, trc_pc, trc_data, commit_cnt;
    logic        trc_valid;
    logic [4:0]  trc_addr;

    logic [31:0] wr1_data, wr2_data, wtrc_pc, wtrc_data;
    logic        wtrc_valid;
    logic [4:0]  wtrc_addr;
    logic [3:0]  wcommit_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    grf_wb dut (
        .clk(clk), .reset(reset), .w_en(w_en), .w_pc(w_pc), .w_addr(w_addr), .w_data(w_data),
        .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_data(r1_data), .r2_data(r2_data),
        .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_addr(trc_addr), .trc_data(trc_data),
        .commit_cnt(commit_cnt)
    );

    grf_wb #(.CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .w_en(w_en), .w_pc(w_pc), .w_addr(w_addr), .w_data(w_data),
        .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_data(wr1_data), .r2_data(wr2_data),
        .trc_valid(wtrc_valid), .trc_pc(wtrc_pc), .trc_addr(wtrc_addr), .trc_data(wtrc_data),
        .commit_cnt(wcommit_cnt)
    );

    // Inputs change on the falling edge; combinational checks follow 1 ns later.
    task automatic drive(input logic rst, input logic en, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] pc,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        @(negedge clk);
        reset = rst; w_en = en; w_addr = wa; w_data = wd; w_pc = pc;
        r1_addr = ra1; r2_addr = ra2;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b1, 5'd5, 32'hDEAD, 32'h0, 5'd5, 5'd0);
            tests++;
            if (r1_data !== 32'h0 || r2_data !== 32'h0) begin
                fails++;
                $display("FAIL reset_read: r1=%h r2=%h expected 0 0", r1_data, r2_data);
            end
            after_edge();
        end
        tests++;
        if (trc_valid !== 1'b0 || trc_pc !== 32'h3000 || commit_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: valid=%b pc=%h cnt=%0d expected 0 3000 0",
                     trc_valid, trc_pc, commit_cnt);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);
        tests++;
        if (r1_data !== 32'h0 || r2_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_discard: r1=%h r2=%h expected 0 0", r1_data, r2_data);
        end
    endtask

    task automatic test_basic_commit();
        drive(1'b0, 1'b1, 5'd8, 32'h1234_5678, 32'h3004, 5'd8, 5'd0);
        tests++;
        if (r1_data !== 32'h1234_5678) begin
            fails++;
            $display("FAIL basic_bypass: r1=%h expected 12345678", r1_data);
        end
        after_edge();
        drive(1'b0, 1'b0, 5'd8, 32'h0, 32'h0, 5'd8, 5'd0);
        tests++;
        if (r1_data !== 32'h1234_5678) begin
            fails++;
            $display("FAIL basic_stored: r1=%h expected 12345678", r1_data);
        end
        tests++;
        if (trc_valid !== 1'b1 || trc_addr !== 5'd8 || trc_pc !== 32'h3004 ||
            trc_data !== 32'h1234_5678 || commit_cnt !== 32'd1) begin
            fails++;
            $display("FAIL basic_trace: valid=%b addr=%0d pc=%h data=%h cnt=%0d expected 1 8 3004 12345678 1",
                     trc_valid, trc_addr, trc_pc, trc_data, commit_cnt);
        end
        after_edge();
        tests++;
        if (trc_valid !== 1'b0 || trc_pc !== 32'h3004 || trc_addr !== 5'd8) begin
            fails++;
            $display("FAIL basic_hold: valid=%b pc=%h addr=%0d expected 0 3004 8",
                     trc_valid, trc_pc, trc_addr);
        end
    endtask

    task automatic test_zero_protect();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h3008, 5'd0, 5'd0);
            tests++;
            if (r1_data !== 32'h0 || r2_data !== 32'h0) begin
                fails++;
                $display("FAIL zero_read: r1=%h r2=%h expected 0 0", r1_data, r2_data);
            end
            after_edge();
            tests++;
            if (trc_valid !== 1'b0 || commit_cnt !== 32'd1 || r1_data !== 32'h0) begin
                fails++;
                $display("FAIL zero_effect: valid=%b cnt=%0d r1=%h expected 0 1 0",
                         trc_valid, commit_cnt, r1_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 5'd3, 32'hA, 32'h300C, 5'd3, 5'd3);
        tests++;
        if (r1_data !== 32'hA || r2_data !== 32'hA) begin
            fails++;
            $display("FAIL b2b_first: r1=%h r2=%h expected a a", r1_data, r2_data);
        end
        drive(1'b0, 1'b1, 5'd3, 32'hB, 32'h3010, 5'd3, 5'd3);
        tests++;
        if (r1_data !== 32'hB || r2_data !== 32'hB) begin
            fails++;
            $display("FAIL b2b_second: r1=%h r2=%h expected b b", r1_data, r2_data);
        end
        drive(1'b0, 1'b0, 5'd3, 32'h0, 32'h0, 5'd3, 5'd3);
        tests++;
        if (r1_data !== 32'hB || r2_data !== 32'hB || commit_cnt !== 32'd3 ||
            trc_data !== 32'hB || trc_pc !== 32'h3010) begin
            fails++;
            $display("FAIL b2b_after: r1=%h r2=%h cnt=%0d tdata=%h tpc=%h expected b b 3 b 3010",
                     r1_data, r2_data, commit_cnt, trc_data, trc_pc);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b0, 1'b1, 5'd9, 32'h55, 32'h3014, 5'd9, 5'd10);
        drive(1'b1, 1'b1, 5'd10, 32'h66, 32'h3018, 5'd9, 5'd10);
        tests++;
        if (r1_data !== 32'h0 || r2_data !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset_read: r1=%h r2=%h expected 0 0", r1_data, r2_data);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd10);
        tests++;
        if (r1_data !== 32'h0 || r2_data !== 32'h0 || commit_cnt !== 32'd0 ||
            trc_valid !== 1'b0 || trc_pc !== 32'h3000) begin
            fails++;
            $display("FAIL mid_reset_state: r1=%h r2=%h cnt=%0d valid=%b pc=%h expected 0 0 0 0 3000",
                     r1_data, r2_data, commit_cnt, trc_valid, trc_pc);
        end
    endtask

    task automatic test_counter_wrap();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b0, 1'b1, 5'd1, 32'(i), 32'h3000 + 32'(4 * i), 5'd1, 5'd0);
            after_edge();
            tests++;
            if (wtrc_valid !== 1'b1 || wtrc_data !== 32'(i)) begin
                fails++;
                $display("FAIL wrap_pulse_hi: i=%0d valid=%b data=%0d expected 1 %0d",
                         i, wtrc_valid, wtrc_data, i);
            end
            drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd0);
            after_edge();
            tests++;
            if (wtrc_valid !== 1'b0) begin
                fails++;
                $display("FAIL wrap_pulse_lo: i=%0d valid=%b expected 0", i, wtrc_valid);
            end
        end
        tests++;
        if (wcommit_cnt !== 4'd1 || commit_cnt !== 32'd17 || wr1_data !== 32'd17) begin
            fails++;
            $display("FAIL wrap_count: cnt4=%0d cnt32=%0d r1=%0d expected 1 17 17",
                     wcommit_cnt, commit_cnt, wr1_data);
        end
    endtask

    initial begin
        reset = 1'b1; w_en = 1'b0; w_pc = '0; w_addr = '0; w_data = '0;
        r1_addr = '0; r2_addr = '0;
        test_reset();
        test_basic_commit();
        test_zero_protect();
        test_back_to_back();
        test_reset_midstream();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
